// File: rtl/vec_dot_accumulator_if.sv
// Handshake bundle between the multiplier, the dot-product accumulator and lane writeback.
interface vec_dot_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_LEN   = 16,
  parameter int LEN_W     = $clog2(MAX_LEN) + 1,
  parameter int ACC_WIDTH = 2 * WIDTH + $clog2(MAX_LEN)
);
  logic                   start;
  logic [LEN_W-1:0]       len;
  logic [2*WIDTH-1:0]     product;
  logic                   prod_valid;
  logic                   prod_ready;
  logic [ACC_WIDTH-1:0]   result;
  logic                   res_valid;
  logic                   res_ready;
  logic                   busy;
  logic                   overflow;

  modport master (
    output start, len, product, prod_valid, res_ready,
    input  prod_ready, result, res_valid, busy, overflow
  );

  modport slave (
    input  start, len, product, prod_valid, res_ready,
    output prod_ready, result, res_valid, busy, overflow
  );
endinterface

// File: rtl/vec_dot_accumulator.sv
// Signed dot-product accumulator: sums len products and hands the result downstream.
// Optional saturating adds with a sticky overflow flag under `VEC_DOT_ACC_SAT_EN.
module vec_dot_accumulator #(
  parameter int WIDTH     = 8,
  parameter int MAX_LEN   = 16,
  parameter int LEN_W     = $clog2(MAX_LEN) + 1,
  parameter int ACC_WIDTH = 2 * WIDTH + $clog2(MAX_LEN)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  vec_dot_accumulator_if.slave  bus
);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]     cnt_q, len_q;
  logic                 prod_rdy_q, res_vld_q, busy_q, ovf_q;
  logic                 clamp;
  logic                 hs;

`ifdef VEC_DOT_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [ACC_WIDTH:0] sum_w;

  // One guard bit catches signed overflow; clamp toward the sign of the true sum.
  always_comb begin
    sum_w = {acc_q[ACC_WIDTH-1], acc_q} + (ACC_WIDTH+1)'($signed(bus.product));
    clamp = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];
    acc_d = sum_w[ACC_WIDTH-1:0];
    if (clamp) acc_d = sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end
`else
  always_comb begin
    acc_d = acc_q + ACC_WIDTH'($signed(bus.product));
  end
  assign clamp = 1'b0;
`endif

  assign hs = bus.prod_valid && prod_rdy_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      prod_rdy_q <= 1'b0;
      res_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          acc_q  <= '0;
          cnt_q  <= '0;
          ovf_q  <= 1'b0;
          busy_q <= 1'b1;
          if (bus.len != '0) begin
            len_q      <= bus.len;
            state_q    <= ACCUM;
            prod_rdy_q <= 1'b1;
          end else begin
            state_q   <= DONE;
            res_vld_q <= 1'b1;
          end
        end
        ACCUM: if (hs) begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + LEN_W'(1);
          ovf_q <= ovf_q | clamp;
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_q    <= DONE;
            prod_rdy_q <= 1'b0;
            res_vld_q  <= 1'b1;
          end
        end
        DONE: if (bus.res_ready) begin
          state_q   <= IDLE;
          res_vld_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          prod_rdy_q <= 1'b0;
          res_vld_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prod_ready = prod_rdy_q;
  assign bus.res_valid  = res_vld_q;
  assign bus.result     = acc_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: doc/vec_dot_accumulator.md
# vec_dot_accumulator

Signed accumulator that sits directly downstream of the booth_wallace_multiplier in a vector lane. It consumes one signed product per cycle over a valid/ready handshake and sums a programmed number of products into one dot-product result. It presents that result on a second valid/ready port to the lane writeback. Products are sign-extended to the accumulator width before they are added.

## Interface
- WIDTH, 8, multiplier operand width; the product input is 2*WIDTH bits
- MAX_LEN, 16, maximum number of elements per dot product
- LEN_W, $clog2(MAX_LEN)+1, width of the element-count input
- ACC_WIDTH, 2*WIDTH+$clog2(MAX_LEN), accumulator and result width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  begin a new dot product; sampled only in IDLE
- len  in  LEN_W  element count, captured with start; legal range 0..MAX_LEN
- product  in  2*WIDTH  signed product from the multiplier
- prod_valid  in  1  product is valid
- prod_ready  out  1  accumulator accepts a product this cycle
- result  out  ACC_WIDTH  signed dot-product result
- res_valid  out  1  result is valid
- res_ready  in  1  downstream accepts the result
- busy  out  1  high in ACCUM and DONE
- overflow  out  1  sticky saturation flag for the current result (tied 0 without the macro)

## Operation
- Three states: IDLE, ACCUM, DONE. Encoding is free; registered state.
- IDLE:
  - start=1 with len!=0: capture len into len_q, clear acc and count, go to ACCUM.
  - start=1 with len==0: clear acc, go directly to DONE (result 0).
  - start=0: stay in IDLE.
- ACCUM:
  - prod_ready=1.
  - Each cycle with prod_valid && prod_ready: acc <= acc + sign_extend(product) and count <= count+1.
  - Handshake when count==len_q-1: go to DONE.
  - No handshake: hold state, acc and count.
- DONE:
  - res_valid=1, result=acc, both held stable until res_ready=1.
  - res_valid && res_ready: go to IDLE.
- start is ignored outside IDLE and is not queued.
- len > MAX_LEN is illegal; the behaviour is undefined, and the bench does not drive it.
- Arithmetic is two's complement at ACC_WIDTH. At default parameters the sum cannot overflow (|sum| ≤ 16·16384 = 2^18).

## Timing
- Reset (rst_n=0 at a clock edge): state=IDLE, acc=0, count=0, len_q=0, prod_ready=0, res_valid=0, result=0, busy=0, overflow=0.
- Reset asserted mid-operation aborts the dot product. Any partial sum is discarded and no result is produced.
- prod_ready and res_valid are decoded from the registered state only. Neither depends combinationally on prod_valid or res_ready.
- The first prod_ready=1 appears in the cycle after start is sampled.
- Throughput is one product per cycle. Stalls on prod_valid=0 are allowed anywhere in ACCUM.
- res_valid rises in the cycle after the last product handshake.
- Minimum time from start to res_valid for len=N with no stalls: N+1 cycles.
- In the res_valid && res_ready cycle the state moves to IDLE. A start in that same cycle is ignored; the earliest start accepted is in the following cycle.
- prod_valid during IDLE or DONE is not consumed, because prod_ready=0.

## Configuration
- Macro: VEC_DOT_ACC_SAT_EN.
- Defined:
  - Each add saturates to the signed ACC_WIDTH range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - On any clamp, overflow sets and stays set through DONE.
  - overflow is cleared when a new start is accepted, and on reset.
- Undefined:
  - The sum wraps modulo 2^ACC_WIDTH.
  - overflow is constant 0.

## Test plan
- Reset: hold rst_n=0 for 2 cycles while driving start=1 and prod_valid=1 -> all outputs 0; after release, state is IDLE and prod_ready=0.
- Basic dot product: len=4, products 100, -50, 16384, -1, no stalls -> res_valid 5 cycles after start, result=16433; hold res_ready=0 for 3 cycles and check result and res_valid stay stable.
- Stalls and backpressure: len=3, products -16256, -16256, 127 with prod_valid=0 gaps of 2 cycles between them -> result=-32385. A start pulse issued during ACCUM is ignored.
- Zero length: len=0 -> res_valid in the cycle after start, result=0, prod_ready never asserted.
- Saturation (ACC_WIDTH=16 override): len=3, products 16384, 16384, 16384.
  - With VEC_DOT_ACC_SAT_EN: result=32767, overflow=1.
  - Without it: result=-16384, overflow=0.
- Abort and back-to-back: assert rst_n=0 after 2 of 4 products -> no res_valid appears. Then run len=1 with product 7, with start asserted in the same cycle as res_ready -> that start is ignored, a start one cycle later is accepted, and the new result is correct.
